// File: rtl/mipi_csi_pkg.sv
`default_nettype none
//==============================================================================
// Module   : mipi_csi_pkg
// Desc     : CSI-2 data-type codes, packet-header field offsets and decoder
//            state encoding shared by the packet decoder and its ECC helper.
// Revision : 1.0 - initial release
//==============================================================================
package mipi_csi_pkg;

    localparam logic [5:0] c_DT_FS    = 6'h00;
    localparam logic [5:0] c_DT_FE    = 6'h01;
    localparam logic [5:0] c_DT_RAW10 = 6'h2B;

    localparam int c_HDR_DT_LSB  = 0;
    localparam int c_HDR_VC_LSB  = 6;
    localparam int c_HDR_WC_LSB  = 8;
    localparam int c_HDR_ECC_LSB = 24;
    localparam int c_WC_W        = 16;

    // Holds ceil(WC/4) for the largest 16-bit word count
    localparam int c_REM_W = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_SKIP    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mipi_csi_ecc.sv
`default_nettype none
//==============================================================================
// Module   : mipi_csi_ecc
// Desc     : Combinational CSI-2 packet-header Hamming ECC, 24 header bits to
//            6 parity bits (the two upper ECC byte bits are always zero).
// Revision : 1.0 - initial release
//==============================================================================
module mipi_csi_ecc (
    input  logic [23:0] i_header,
    output logic [5:0]  o_ecc
);

    logic [23:0] d;
    assign d = i_header;

    assign o_ecc[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11]
                    ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    assign o_ecc[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12]
                    ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    assign o_ecc[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12]
                    ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
    assign o_ecc[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14]
                    ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
    assign o_ecc[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17]
                    ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
    assign o_ecc[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16]
                    ^ d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];

endmodule
`default_nettype wire

// File: rtl/mipi_csi_packet_decoder.sv
`default_nettype none
//==============================================================================
// Module   : mipi_csi_packet_decoder
// Desc     : Parses CSI-2 packet headers from 32-bit HS burst words, forwards
//            matching long-packet payload and tracks line/frame framing.
//            Define MIPI_ECC_CHECK_EN to reject headers with a bad ECC byte.
// Revision : 1.0 - initial release
//==============================================================================
module mipi_csi_packet_decoder
    import mipi_csi_pkg::*;
#(
    parameter logic [5:0] DATA_TYPE  = c_DT_RAW10,
    parameter logic [1:0] VIRT_CHAN  = 2'd0,
    parameter int         LINE_CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  data_valid_i,
    input  logic [31:0]           data_i,
    output logic                  output_valid_o,
    output logic [31:0]           output_o,
    output logic                  line_valid_o,
    output logic                  frame_valid_o,
    output logic [LINE_CNT_W-1:0] line_count_o,
    output logic                  packet_err_o
);

    state_t                r_state, w_state_nx;
    logic [c_REM_W-1:0]    r_remaining, w_remaining_nx;
    logic [31:0]           r_output, w_output_nx;
    logic                  r_output_valid, w_output_valid_nx;
    logic                  r_line_valid, w_line_valid_nx;
    logic                  r_frame_valid, w_frame_valid_nx;
    logic [LINE_CNT_W-1:0] r_line_count, w_line_count_nx;
    logic                  r_packet_err, w_packet_err_nx;

    logic [5:0]            w_dt;
    logic [1:0]            w_vc;
    logic [c_WC_W-1:0]     w_wc;
    logic [c_REM_W-1:0]    w_wc_words;
    logic                  w_vc_match, w_is_fs, w_is_fe, w_is_long;
    logic                  w_hdr_ok, w_last, w_cnt_max;

    assign w_dt       = data_i[c_HDR_DT_LSB +: 6];
    assign w_vc       = data_i[c_HDR_VC_LSB +: 2];
    assign w_wc       = data_i[c_HDR_WC_LSB +: c_WC_W];
    assign w_wc_words = c_REM_W'(({1'b0, w_wc} + 17'd3) >> 2);
    assign w_vc_match = (w_vc == VIRT_CHAN);
    assign w_is_fs    = w_vc_match && (w_dt == c_DT_FS);
    assign w_is_fe    = w_vc_match && (w_dt == c_DT_FE);
    assign w_is_long  = w_vc_match && (w_dt == DATA_TYPE) && (w_wc != '0);
    assign w_last     = (r_remaining == c_REM_W'(1));
    assign w_cnt_max  = &r_line_count;

`ifdef MIPI_ECC_CHECK_EN
    logic [5:0] w_ecc_calc;

    mipi_csi_ecc u_ecc (
        .i_header (data_i[c_HDR_ECC_LSB-1:0]),
        .o_ecc    (w_ecc_calc)
    );

    assign w_hdr_ok = (data_i[c_HDR_ECC_LSB +: 8] == {2'b00, w_ecc_calc});
`else
    logic w_unused_ecc;
    assign w_unused_ecc = &{1'b0, data_i[c_HDR_ECC_LSB +: 8]};
    assign w_hdr_ok     = 1'b1;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (data_valid_i) begin
                    w_state_nx = (w_hdr_ok && w_is_long) ? ST_PAYLOAD : ST_SKIP;
                end
            end
            ST_PAYLOAD: begin
                if (!data_valid_i) begin
                    w_state_nx = ST_IDLE;
                end else if (w_last) begin
                    w_state_nx = ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (!data_valid_i) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        w_output_nx       = r_output;
        w_output_valid_nx = 1'b0;
        w_line_valid_nx   = 1'b0;
        w_packet_err_nx   = 1'b0;
        w_frame_valid_nx  = r_frame_valid;
        w_line_count_nx   = r_line_count;
        w_remaining_nx    = r_remaining;
        case (r_state)
            ST_IDLE: begin
                if (data_valid_i) begin
                    if (!w_hdr_ok) begin
                        w_packet_err_nx = 1'b1;
                    end else if (w_is_fs) begin
                        w_frame_valid_nx = 1'b1;
                        w_line_count_nx  = '0;
                    end else if (w_is_fe) begin
                        w_frame_valid_nx = 1'b0;
                    end else if (w_is_long) begin
                        w_remaining_nx = w_wc_words;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (data_valid_i) begin
                    w_output_nx       = data_i;
                    w_output_valid_nx = 1'b1;
                    w_line_valid_nx   = 1'b1;
                    w_remaining_nx    = r_remaining - c_REM_W'(1);
                    if (w_last && !w_cnt_max) begin
                        w_line_count_nx = r_line_count + LINE_CNT_W'(1);
                    end
                end else begin
                    // Burst ended before the word count was satisfied
                    w_packet_err_nx = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_remaining    <= '0;
            r_output       <= '0;
            r_output_valid <= 1'b0;
            r_line_valid   <= 1'b0;
            r_frame_valid  <= 1'b0;
            r_line_count   <= '0;
            r_packet_err   <= 1'b0;
        end else begin
            r_remaining    <= w_remaining_nx;
            r_output       <= w_output_nx;
            r_output_valid <= w_output_valid_nx;
            r_line_valid   <= w_line_valid_nx;
            r_frame_valid  <= w_frame_valid_nx;
            r_line_count   <= w_line_count_nx;
            r_packet_err   <= w_packet_err_nx;
        end
    end

    assign output_valid_o = r_output_valid;
    assign output_o       = r_output;
    assign line_valid_o   = r_line_valid;
    assign frame_valid_o  = r_frame_valid;
    assign line_count_o   = r_line_count;
    assign packet_err_o   = r_packet_err;

endmodule
`default_nettype wire

// File: tb/tb_mipi_csi_packet_decoder.sv
`default_nettype none
//==============================================================================
// Module   : tb_mipi_csi_packet_decoder
// Desc     : Directed self-checking bench for mipi_csi_packet_decoder.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mipi_csi_packet_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        dv;
    logic [31:0] din;
    logic        ov, lv, fv, err;
    logic [31:0] dout;
    logic [15:0] lcnt;

    mipi_csi_packet_decoder dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .data_valid_i   (dv),
        .data_i         (din),
        .output_valid_o (ov),
        .output_o       (dout),
        .line_valid_o   (lv),
        .frame_valid_o  (fv),
        .line_count_o   (lcnt),
        .packet_err_o   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int          n_out, n_lv, n_err;
    logic [31:0] rx_q[$];
    int          rx_cyc[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (ov) begin
                rx_q.push_back(dout);
                rx_cyc.push_back(cyc);
                n_out++;
            end
            if (lv)  n_lv++;
            if (err) n_err++;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Parity masks: bit k of mask j set when header bit k feeds ECC bit j
    function automatic logic [7:0] ecc_of(input logic [23:0] d);
        logic [23:0] m[6];
        logic [7:0]  e;
        m[0] = 24'hF12CB7; m[1] = 24'hF2555B; m[2] = 24'h749A6D;
        m[3] = 24'hB8E38E; m[4] = 24'hDF03F0; m[5] = 24'hEFFC00;
        e = 8'h00;
        for (int j = 0; j < 6; j++) e[j] = ^(d & m[j]);
        return e;
    endfunction

    function automatic logic [31:0] hdr(input logic [1:0] vc, input logic [5:0] dt,
                                        input logic [15:0] wc);
        logic [23:0] d;
        d = {wc, vc, dt};
        return {ecc_of(d), d};
    endfunction

    logic [31:0] tx_q[$];
    logic [31:0] pay_q[$];
    int          drv_cyc1;
    int          exp_cnt;

    task automatic drive(input logic v, input logic [31:0] d);
        @(posedge clk);
        #1;
        dv  = v;
        din = d;
    endtask

    task automatic clear_mon();
        n_out = 0; n_lv = 0; n_err = 0;
        rx_q.delete();
        rx_cyc.delete();
    endtask

    // Header, npay payload words, optional CRC word
    task automatic build(input logic [31:0] h, input int npay, input bit crc);
        tx_q.delete();
        pay_q.delete();
        tx_q.push_back(h);
        for (int i = 0; i < npay; i++) begin
            pay_q.push_back(32'hD000_0000 | (h[15:0] << 8) | 32'(i + 1));
            tx_q.push_back(pay_q[i]);
        end
        if (crc) tx_q.push_back(32'hCCCC_5A5A);
    endtask

    task automatic send();
        clear_mon();
        for (int i = 0; i < tx_q.size(); i++) begin
            drive(1'b1, tx_q[i]);
            if (i == 1) drv_cyc1 = cyc;
        end
        drive(1'b0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; dv = 1'b0; din = 32'h0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ov",  32'(ov),   32'h0);
        chk("rst_lv",  32'(lv),   32'h0);
        chk("rst_fv",  32'(fv),   32'h0);
        chk("rst_cnt", 32'(lcnt), 32'h0);
        chk("rst_err", 32'(err),  32'h0);
        chk("rst_out", dout,      32'h0);
        rst = 1'b0;
        exp_cnt = 0;

        // Frame Start short packet
        build(hdr(2'd0, 6'h00, 16'h0000), 0, 1'b1);
        send();
        chk("fs_fv",  32'(fv),    32'h1);
        chk("fs_cnt", 32'(lcnt),  32'h0);
        chk("fs_out", 32'(n_out), 32'h0);

        // RAW10 line, WC=20 -> 5 words
        build(hdr(2'd0, 6'h2B, 16'd20), 5, 1'b1);
        send();
        exp_cnt = 1;
        chk("l1_nout", 32'(n_out), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("l1_d%0d", i), rx_q[i], pay_q[i]);
        chk("l1_lat", (rx_cyc.size() > 0) ? 32'(rx_cyc[0] - drv_cyc1) : 32'hFFFF_FFFF, 32'd1);
        chk("l1_nlv", 32'(n_lv),  32'd5);
        chk("l1_cnt", 32'(lcnt),  32'(exp_cnt));
        chk("l1_err", 32'(n_err), 32'd0);

        // RAW12 line is not ours
        build(hdr(2'd0, 6'h2C, 16'd20), 5, 1'b1);
        send();
        chk("r12_nout", 32'(n_out), 32'd0);
        chk("r12_nlv",  32'(n_lv),  32'd0);
        chk("r12_cnt",  32'(lcnt),  32'(exp_cnt));

        // Truncated after 3 of 5 words
        build(hdr(2'd0, 6'h2B, 16'd20), 3, 1'b0);
        send();
        chk("tr_nout", 32'(n_out), 32'd3);
        chk("tr_d2",   rx_q[2],    pay_q[2]);
        chk("tr_err",  32'(n_err), 32'd1);
        chk("tr_nlv",  32'(n_lv),  32'd3);
        chk("tr_cnt",  32'(lcnt),  32'(exp_cnt));

        // Corrupted ECC byte
        build(hdr(2'd0, 6'h2B, 16'd8) ^ 32'h0100_0000, 2, 1'b1);
        send();
`ifdef MIPI_ECC_CHECK_EN
        chk("ecc_nout", 32'(n_out), 32'd0);
        chk("ecc_err",  32'(n_err), 32'd1);
`else
        exp_cnt++;
        chk("ecc_nout", 32'(n_out), 32'd2);
        chk("ecc_err",  32'(n_err), 32'd0);
`endif
        chk("ecc_cnt", 32'(lcnt), 32'(exp_cnt));

        // WC=6 -> 2 words, last one partially used
        build(hdr(2'd0, 6'h2B, 16'd6), 2, 1'b1);
        send();
        exp_cnt++;
        chk("wc6_nout", 32'(n_out), 32'd2);
        chk("wc6_d1",   rx_q[1],    pay_q[1]);
        chk("wc6_cnt",  32'(lcnt),  32'(exp_cnt));

        // Wrong virtual channel
        build(hdr(2'd1, 6'h2B, 16'd8), 2, 1'b1);
        send();
        chk("vc_nout", 32'(n_out), 32'd0);
        chk("vc_cnt",  32'(lcnt),  32'(exp_cnt));

        // FS while frame already open clears the count
        build(hdr(2'd0, 6'h00, 16'h0001), 0, 1'b0);
        send();
        chk("fs2_fv",  32'(fv),   32'h1);
        chk("fs2_cnt", 32'(lcnt), 32'h0);

        for (int k = 0; k < 3; k++) begin
            build(hdr(2'd0, 6'h2B, 16'd4), 1, 1'b1);
            send();
            chk($sformatf("ln%0d_nout", k), 32'(n_out), 32'd1);
        end

        build(hdr(2'd0, 6'h01, 16'h0001), 0, 1'b1);
        send();
        chk("fe_fv",  32'(fv),   32'h0);
        chk("fe_cnt", 32'(lcnt), 32'd3);

        // Reset in the middle of a payload
        clear_mon();
        drive(1'b1, hdr(2'd0, 6'h2B, 16'd20));
        drive(1'b1, 32'h1234_5678);
        drive(1'b1, 32'h9ABC_DEF0);
        @(posedge clk);
        #2;
        chk("mr_ov_pre", 32'(ov), 32'h1);
        rst = 1'b1;
        #1;
        chk("mr_ov",  32'(ov),   32'h0);
        chk("mr_lv",  32'(lv),   32'h0);
        chk("mr_cnt", 32'(lcnt), 32'h0);
        chk("mr_out", dout,      32'h0);
        chk("mr_err", 32'(err),  32'h0);
        @(negedge clk);
        dv = 1'b0; din = 32'h0;
        @(negedge clk);
        rst = 1'b0;

        // Clean line after reset
        build(hdr(2'd0, 6'h2B, 16'd8), 2, 1'b1);
        send();
        chk("pr_nout", 32'(n_out), 32'd2);
        chk("pr_cnt",  32'(lcnt),  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
